ram_tdp_param: RTL and testbench

//  Parametrised true dual-port RAM, single clock, two independent read/write ports A and B.

---
 rtl/ram_tdp_pkg.sv | 25 ++
 rtl/ram_tdp_coll_mon.sv | 46 ++++
 rtl/ram_tdp_param.sv | 126 ++++++++++++
 tb/tb_ram_tdp_param.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_tdp_pkg.sv
// Shared types and helpers for the true dual-port RAM and its collision monitor.
package ram_tdp_pkg;

    typedef enum logic {READ_FIRST = 1'b0, WRITE_FIRST = 1'b1} rdw_mode_e;
    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

    localparam int COLL_CNT_W  = 16;
    localparam int MERGE_MAX_W = 256;

    // Lane-wise merge on a wide carrier; callers zero-extend in and truncate out.
    function automatic logic [MERGE_MAX_W-1:0] be_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_W-1:0] be,
        input int                     byte_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            if (be[i / byte_w]) res[i] = new_w[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_tdp_coll_mon.sv
// Write-write collision detection, winner lane mask, registered pulse and saturating counter.
module ram_tdp_coll_mon
    import ram_tdp_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int NB        = 1,
    parameter int COLL_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_a,
    input  logic                  wr_b,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [NB-1:0]         be_a,
    input  logic [NB-1:0]         be_b,
    output logic                  same_wr,
    output logic [NB-1:0]         lane_b,
    output logic                  coll,
    output logic [COLL_CNT_W-1:0] coll_cnt
);

    localparam prio_e PRIO = prio_e'(COLL_PRIO[0]);

    logic hit;

    always_comb begin
        same_wr = wr_a & wr_b & (addr_a == addr_b);
        hit     = same_wr & (|(be_a & be_b));
        // Lanes where port B's data ends up in the stored word.
        lane_b  = (PRIO == PRIO_B) ? be_b : (be_b & ~be_a);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= hit;
            if (hit && (coll_cnt != {COLL_CNT_W{1'b1}})) begin
                coll_cnt <= coll_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_tdp_param.sv
// Single-clock true dual-port RAM with byte enables, RDW mode and write collision resolution.
// Define TDPRAM_OUTREG_EN to add an output register on q/vld of both ports (latency 2).
module ram_tdp_param
    import ram_tdp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BYTE_W    = 8,
    parameter int RDW_MODE  = 0,
    parameter int COLL_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_a,
    input  logic                      we_a,
    input  logic [DATA_W/BYTE_W-1:0]  be_a,
    input  logic [ADDR_W-1:0]         addr_a,
    input  logic [DATA_W-1:0]         data_a,
    output logic [DATA_W-1:0]         q_a,
    output logic                      vld_a,
    input  logic                      en_b,
    input  logic                      we_b,
    input  logic [DATA_W/BYTE_W-1:0]  be_b,
    input  logic [ADDR_W-1:0]         addr_b,
    input  logic [DATA_W-1:0]         data_b,
    output logic [DATA_W-1:0]         q_b,
    output logic                      vld_b,
    output logic                      coll,
    output logic [COLL_CNT_W-1:0]     coll_cnt
);

    localparam int        NB    = DATA_W / BYTE_W;
    localparam int        DEPTH = 1 << ADDR_W;
    localparam rdw_mode_e RDW   = rdw_mode_e'(RDW_MODE[0]);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_a, wr_b, same_wr;
    logic [NB-1:0]     lane_b;
    logic [DATA_W-1:0] old_a, old_b, own_a, own_b, both_w, word_a, word_b;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              rv_a, rv_b;

    // Reset gates writes here so the array itself never needs a reset.
    assign wr_a = en_a & we_a & rst_n & (|be_a);
    assign wr_b = en_b & we_b & rst_n & (|be_b);

    ram_tdp_coll_mon #(
        .ADDR_W    (ADDR_W),
        .NB        (NB),
        .COLL_PRIO (COLL_PRIO)
    ) u_coll (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .be_a     (be_a),
        .be_b     (be_b),
        .same_wr  (same_wr),
        .lane_b   (lane_b),
        .coll     (coll),
        .coll_cnt (coll_cnt)
    );

    always_comb begin
        old_a  = mem[addr_a];
        old_b  = mem[addr_b];
        own_a  = DATA_W'(be_merge(MERGE_MAX_W'(old_a), MERGE_MAX_W'(data_a), MERGE_MAX_W'(be_a), BYTE_W));
        own_b  = DATA_W'(be_merge(MERGE_MAX_W'(old_b), MERGE_MAX_W'(data_b), MERGE_MAX_W'(be_b), BYTE_W));
        // Same-address writes: A's merge first, then B's winning lanes on top.
        both_w = DATA_W'(be_merge(MERGE_MAX_W'(own_a), MERGE_MAX_W'(data_b), MERGE_MAX_W'(lane_b), BYTE_W));
        word_a = same_wr ? both_w : own_a;
        word_b = same_wr ? both_w : own_b;
    end

    always_ff @(posedge clk) begin
        if (wr_a) mem[addr_a] <= word_a;
        if (wr_b) mem[addr_b] <= word_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_a <= '0;
            rd_b <= '0;
            rv_a <= 1'b0;
            rv_b <= 1'b0;
        end else begin
            rv_a <= en_a;
            rv_b <= en_b;
            if (en_a) rd_a <= ((RDW == WRITE_FIRST) && wr_a) ? word_a : old_a;
            if (en_b) rd_b <= ((RDW == WRITE_FIRST) && wr_b) ? word_b : old_b;
        end
    end

`ifdef TDPRAM_OUTREG_EN
    logic [DATA_W-1:0] q_a_r, q_b_r;
    logic              vld_a_r, vld_b_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a_r   <= '0;
            q_b_r   <= '0;
            vld_a_r <= 1'b0;
            vld_b_r <= 1'b0;
        end else begin
            vld_a_r <= rv_a;
            vld_b_r <= rv_b;
            if (rv_a) q_a_r <= rd_a;
            if (rv_b) q_b_r <= rd_b;
        end
    end

    assign q_a   = q_a_r;
    assign q_b   = q_b_r;
    assign vld_a = vld_a_r;
    assign vld_b = vld_b_r;
`else
    assign q_a   = rd_a;
    assign q_b   = rd_b;
    assign vld_a = rv_a;
    assign vld_b = rv_b;
`endif

endmodule

// File: tb/tb_ram_tdp_param.sv
// Directed bench for ram_tdp_param: two instances (read-first/prio A and write-first/prio B).
module tb_ram_tdp_param;

`ifdef TDPRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, we_a, en_b, we_b;
    logic [1:0]  be_a, be_b;
    logic [5:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;

    logic [15:0] q0_a, q0_b, q1_a, q1_b;
    logic        vld0_a, vld0_b, vld1_a, vld1_b, coll0, coll1;
    logic [15:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    ram_tdp_param #(.DATA_W(16), .ADDR_W(6), .BYTE_W(8), .RDW_MODE(0), .COLL_PRIO(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q0_a), .vld_a(vld0_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q0_b), .vld_b(vld0_b),
        .coll(coll0), .coll_cnt(cnt0)
    );

    ram_tdp_param #(.DATA_W(16), .ADDR_W(6), .BYTE_W(8), .RDW_MODE(1), .COLL_PRIO(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q1_a), .vld_a(vld1_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q1_b), .vld_b(vld1_b),
        .coll(coll1), .coll_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic we, input logic [1:0] be,
                           input logic [5:0] addr, input logic [15:0] data);
        en_a = en; we_a = we; be_a = be; addr_a = addr; data_a = data;
    endtask

    task automatic drive_b(input logic en, input logic we, input logic [1:0] be,
                           input logic [5:0] addr, input logic [15:0] data);
        en_b = en; we_b = we; be_b = be; addr_b = addr; data_b = data;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
        drive_b(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    endtask

    // Present the driven access at one edge, then idle until its read data is due.
    task automatic access();
        tick();
        idle();
        repeat (L - 1) tick();
    endtask

    task automatic write_a(input logic [5:0] addr, input logic [15:0] data);
        drive_a(1'b1, 1'b1, 2'b11, addr, data);
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        if (q0_a !== 16'h0000) begin failures++; $display("FAIL reset_q0_a got=%h exp=0000", q0_a); end
        checks++;
        if (q0_b !== 16'h0000) begin failures++; $display("FAIL reset_q0_b got=%h exp=0000", q0_b); end
        checks++;
        if (vld0_a !== 1'b0) begin failures++; $display("FAIL reset_vld0_a got=%b exp=0", vld0_a); end
        checks++;
        if (vld0_b !== 1'b0) begin failures++; $display("FAIL reset_vld0_b got=%b exp=0", vld0_b); end
        checks++;
        if (coll0 !== 1'b0) begin failures++; $display("FAIL reset_coll0 got=%b exp=0", coll0); end
        checks++;
        if (cnt0 !== 16'h0000) begin failures++; $display("FAIL reset_cnt0 got=%h exp=0000", cnt0); end
        checks++;
        if (q1_a !== 16'h0000) begin failures++; $display("FAIL reset_q1_a got=%h exp=0000", q1_a); end
        checks++;
        if (cnt1 !== 16'h0000) begin failures++; $display("FAIL reset_cnt1 got=%h exp=0000", cnt1); end
        checks++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        write_a(6'h00, 16'h00AA);
        drive_b(1'b1, 1'b0, 2'b00, 6'h00, 16'h0000);
        access();
        if (q0_b !== 16'h00AA) begin failures++; $display("FAIL wr_rd_q0_b got=%h exp=00aa", q0_b); end
        checks++;
        if (q1_b !== 16'h00AA) begin failures++; $display("FAIL wr_rd_q1_b got=%h exp=00aa", q1_b); end
        checks++;
        if (vld0_b !== 1'b1) begin failures++; $display("FAIL wr_rd_vld0_b got=%b exp=1", vld0_b); end
        checks++;
        if (vld0_a !== 1'b0) begin failures++; $display("FAIL wr_rd_vld0_a got=%b exp=0", vld0_a); end
        checks++;
        repeat (L) tick();
        if (vld0_b !== 1'b0) begin failures++; $display("FAIL idle_vld0_b got=%b exp=0", vld0_b); end
        checks++;
        if (q0_b !== 16'h00AA) begin failures++; $display("FAIL idle_hold_q0_b got=%h exp=00aa", q0_b); end
        checks++;
    endtask

    task automatic test_byte_enable();
        write_a(6'h03, 16'h1122);
        drive_a(1'b1, 1'b1, 2'b10, 6'h03, 16'hEE55);
        tick();
        drive_a(1'b1, 1'b0, 2'b00, 6'h03, 16'h0000);
        access();
        if (q0_a !== 16'hEE22) begin failures++; $display("FAIL be_hi_q0_a got=%h exp=ee22", q0_a); end
        checks++;
        if (q1_a !== 16'hEE22) begin failures++; $display("FAIL be_hi_q1_a got=%h exp=ee22", q1_a); end
        checks++;
        drive_a(1'b1, 1'b1, 2'b00, 6'h03, 16'hFFFF);
        tick();
        drive_a(1'b1, 1'b0, 2'b00, 6'h03, 16'h0000);
        access();
        if (q0_a !== 16'hEE22) begin failures++; $display("FAIL be_zero_q0_a got=%h exp=ee22", q0_a); end
        checks++;
    endtask

    task automatic test_rdw();
        write_a(6'h05, 16'h0033);
        drive_a(1'b1, 1'b1, 2'b11, 6'h05, 16'h0077);
        drive_b(1'b1, 1'b0, 2'b00, 6'h05, 16'h0000);
        access();
        if (q0_a !== 16'h0033) begin failures++; $display("FAIL rdw_rf_q0_a got=%h exp=0033", q0_a); end
        checks++;
        if (q1_a !== 16'h0077) begin failures++; $display("FAIL rdw_wf_q1_a got=%h exp=0077", q1_a); end
        checks++;
        if (q0_b !== 16'h0033) begin failures++; $display("FAIL rdw_cross_q0_b got=%h exp=0033", q0_b); end
        checks++;
        if (q1_b !== 16'h0033) begin failures++; $display("FAIL rdw_cross_q1_b got=%h exp=0033", q1_b); end
        checks++;
        drive_a(1'b1, 1'b0, 2'b00, 6'h05, 16'h0000);
        access();
        if (q0_a !== 16'h0077) begin failures++; $display("FAIL rdw_after_q0_a got=%h exp=0077", q0_a); end
        checks++;
    endtask

    task automatic test_collision();
        write_a(6'h07, 16'h0101);
        drive_a(1'b1, 1'b1, 2'b11, 6'h07, 16'h0033);
        drive_b(1'b1, 1'b1, 2'b11, 6'h07, 16'h0044);
        tick();
        idle();
        if (coll0 !== 1'b1) begin failures++; $display("FAIL coll_pulse0 got=%b exp=1", coll0); end
        checks++;
        if (coll1 !== 1'b1) begin failures++; $display("FAIL coll_pulse1 got=%b exp=1", coll1); end
        checks++;
        if (cnt0 !== 16'h0001) begin failures++; $display("FAIL coll_cnt0 got=%h exp=0001", cnt0); end
        checks++;
        repeat (L - 1) tick();
        if (q0_a !== 16'h0101) begin failures++; $display("FAIL coll_rdw_q0_a got=%h exp=0101", q0_a); end
        checks++;
        if (q1_a !== 16'h0044) begin failures++; $display("FAIL coll_rdw_q1_a got=%h exp=0044", q1_a); end
        checks++;
        if (q1_b !== 16'h0044) begin failures++; $display("FAIL coll_rdw_q1_b got=%h exp=0044", q1_b); end
        checks++;
        tick();
        if (coll0 !== 1'b0) begin failures++; $display("FAIL coll_pulse_end0 got=%b exp=0", coll0); end
        checks++;
        drive_a(1'b1, 1'b0, 2'b00, 6'h07, 16'h0000);
        access();
        if (q0_a !== 16'h0033) begin failures++; $display("FAIL coll_mem_prio_a got=%h exp=0033", q0_a); end
        checks++;
        if (q1_a !== 16'h0044) begin failures++; $display("FAIL coll_mem_prio_b got=%h exp=0044", q1_a); end
        checks++;
        // Partial overlap: only lane 0 is contested.
        drive_a(1'b1, 1'b1, 2'b11, 6'h08, 16'hAABB);
        drive_b(1'b1, 1'b1, 2'b01, 6'h08, 16'hCCDD);
        tick();
        idle();
        if (cnt0 !== 16'h0002) begin failures++; $display("FAIL coll_part_cnt0 got=%h exp=0002", cnt0); end
        checks++;
        drive_a(1'b1, 1'b0, 2'b00, 6'h08, 16'h0000);
        access();
        if (q0_a !== 16'hAABB) begin failures++; $display("FAIL coll_part_prio_a got=%h exp=aabb", q0_a); end
        checks++;
        if (q1_a !== 16'hAADD) begin failures++; $display("FAIL coll_part_prio_b got=%h exp=aadd", q1_a); end
        checks++;
    endtask

    task automatic test_merge();
        drive_a(1'b1, 1'b1, 2'b01, 6'h06, 16'h0011);
        drive_b(1'b1, 1'b1, 2'b10, 6'h06, 16'h2200);
        tick();
        idle();
        if (coll0 !== 1'b0) begin failures++; $display("FAIL merge_coll0 got=%b exp=0", coll0); end
        checks++;
        if (cnt0 !== 16'h0002) begin failures++; $display("FAIL merge_cnt0 got=%h exp=0002", cnt0); end
        checks++;
        drive_a(1'b1, 1'b0, 2'b00, 6'h06, 16'h0000);
        access();
        if (q0_a !== 16'h2211) begin failures++; $display("FAIL merge_q0_a got=%h exp=2211", q0_a); end
        checks++;
        if (q1_a !== 16'h2211) begin failures++; $display("FAIL merge_q1_a got=%h exp=2211", q1_a); end
        checks++;
    endtask

    task automatic test_diff_addr();
        drive_a(1'b1, 1'b1, 2'b11, 6'h09, 16'h1234);
        drive_b(1'b1, 1'b1, 2'b11, 6'h0A, 16'h5678);
        tick();
        idle();
        if (coll0 !== 1'b0) begin failures++; $display("FAIL diff_coll0 got=%b exp=0", coll0); end
        checks++;
        drive_a(1'b1, 1'b0, 2'b00, 6'h0A, 16'h0000);
        drive_b(1'b1, 1'b0, 2'b00, 6'h09, 16'h0000);
        access();
        if (q0_a !== 16'h5678) begin failures++; $display("FAIL diff_q0_a got=%h exp=5678", q0_a); end
        checks++;
        if (q0_b !== 16'h1234) begin failures++; $display("FAIL diff_q0_b got=%h exp=1234", q0_b); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  addrs [3];
        logic [15:0] vals  [3];
        logic [15:0] exp_w;
        int          seen;
        addrs[0] = 6'h03; vals[0] = 16'hEE22;
        addrs[1] = 6'h05; vals[1] = 16'h0077;
        addrs[2] = 6'h06; vals[2] = 16'h2211;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 3 + L; i++) begin
            if (i < 3) begin
                drive_a(1'b1, 1'b0, 2'b00, addrs[i], 16'h0000);
                exp_q.push_back(vals[i]);
            end else begin
                idle();
            end
            tick();
            if (vld0_a === 1'b1 && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                seen++;
                if (q0_a !== exp_w) begin failures++; $display("FAIL b2b_q0_a got=%h exp=%h", q0_a, exp_w); end
                checks++;
            end
        end
        if (seen != 3) begin failures++; $display("FAIL b2b_vld_count got=%0d exp=3", seen); end
        checks++;
    endtask

    task automatic test_mid_reset();
        write_a(6'h0B, 16'h5A5A);
        drive_a(1'b1, 1'b0, 2'b00, 6'h03, 16'h0000);
        tick();
        rst_n = 1'b0;
        drive_a(1'b1, 1'b1, 2'b11, 6'h0B, 16'hFFFF);
        drive_b(1'b1, 1'b1, 2'b11, 6'h0B, 16'hFFFF);
        tick();
        if (q0_a !== 16'h0000) begin failures++; $display("FAIL mrst_q0_a got=%h exp=0000", q0_a); end
        checks++;
        if (vld0_a !== 1'b0) begin failures++; $display("FAIL mrst_vld0_a got=%b exp=0", vld0_a); end
        checks++;
        if (cnt0 !== 16'h0000) begin failures++; $display("FAIL mrst_cnt0 got=%h exp=0000", cnt0); end
        checks++;
        tick();
        if (coll0 !== 1'b0) begin failures++; $display("FAIL mrst_coll0 got=%b exp=0", coll0); end
        checks++;
        rst_n = 1'b1;
        idle();
        tick();
        drive_a(1'b1, 1'b0, 2'b00, 6'h0B, 16'h0000);
        access();
        if (q0_a !== 16'h5A5A) begin failures++; $display("FAIL mrst_mem_q0_a got=%h exp=5a5a", q0_a); end
        checks++;
        if (q1_a !== 16'h5A5A) begin failures++; $display("FAIL mrst_mem_q1_a got=%h exp=5a5a", q1_a); end
        checks++;
    endtask

    task automatic test_saturation();
        drive_a(1'b1, 1'b1, 2'b11, 6'h10, 16'h1111);
        drive_b(1'b1, 1'b1, 2'b11, 6'h10, 16'h2222);
        repeat (65535) tick();
        if (cnt0 !== 16'hFFFF) begin failures++; $display("FAIL sat_reach_cnt0 got=%h exp=ffff", cnt0); end
        checks++;
        tick();
        idle();
        if (cnt0 !== 16'hFFFF) begin failures++; $display("FAIL sat_hold_cnt0 got=%h exp=ffff", cnt0); end
        checks++;
        if (cnt1 !== 16'hFFFF) begin failures++; $display("FAIL sat_hold_cnt1 got=%h exp=ffff", cnt1); end
        checks++;
        if (coll0 !== 1'b1) begin failures++; $display("FAIL sat_coll0 got=%b exp=1", coll0); end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_merge();
        test_diff_addr();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
